// File: rtl/unison_pkg.sv
`default_nettype none
// ============================================================================
// Module   : unison_pkg
// Brief    : Shared defaults, pulse-pair bit indices and delta decode for the
//            unison I/Q accumulator.
// Revision : 1.0  initial release
// ============================================================================
package unison_pkg;

    localparam int ACC_W_DEF   = 16;
    localparam int FRAME_W_DEF = 12;

    localparam int FB_POS = 0;
    localparam int FB_NEG = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } acc_state_e;

    // Opposing pulses in the same cycle cancel.
    function automatic logic signed [1:0] pm_delta(input logic [1:0] pair);
        if (pair[FB_POS] && !pair[FB_NEG])
            return 2'sd1;
        else if (pair[FB_NEG] && !pair[FB_POS])
            return -2'sd1;
        else
            return 2'sd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unison_iq_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : unison_iq_accumulator_if
// Brief    : Frame readout valid/ready bus. frame_sat present only when
//            UNISON_IQ_SAT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface unison_iq_accumulator_if #(
    parameter int ACC_W = 16
);
    logic signed [ACC_W-1:0] frame_I;
    logic signed [ACC_W-1:0] frame_Q;
    logic                    frame_valid;
    logic                    frame_ready;
    logic [7:0]              frame_seq;
`ifdef UNISON_IQ_SAT_EN
    logic                    frame_sat;
`endif

    modport master (
        output frame_I, frame_Q, frame_valid, frame_seq,
`ifdef UNISON_IQ_SAT_EN
        output frame_sat,
`endif
        input  frame_ready
    );

    modport slave (
        input  frame_I, frame_Q, frame_valid, frame_seq,
`ifdef UNISON_IQ_SAT_EN
        input  frame_sat,
`endif
        output frame_ready
    );
endinterface
`default_nettype wire

// File: rtl/unison_pm_acc.sv
`default_nettype none
// ============================================================================
// Module   : unison_pm_acc
// Brief    : One-channel +/- pulse integrator; wraps, or saturates with a
//            per-frame clip flag when UNISON_IQ_SAT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module unison_pm_acc
    import unison_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_en,
    input  wire logic                    i_clear,
    input  wire logic [1:0]              i_pair,
`ifdef UNISON_IQ_SAT_EN
    output logic                         o_sat_next,
`endif
    output logic signed [ACC_W-1:0]      o_acc_next
);

`ifdef UNISON_IQ_SAT_EN
    localparam int c_SW = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] c_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`else
    localparam int c_SW = ACC_W;
`endif

    logic signed [ACC_W-1:0] r_acc;
    logic signed [1:0]       w_d;
    logic signed [c_SW-1:0]  w_sum;

    assign w_d   = pm_delta(i_pair);
    assign w_sum = c_SW'(r_acc) + c_SW'(w_d);

`ifdef UNISON_IQ_SAT_EN
    logic r_sat;
    logic w_ovf;

    // One guard bit: top two bits disagreeing means the step left the range.
    assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign o_acc_next = w_ovf ? (w_sum[ACC_W] ? c_MIN : c_MAX) : w_sum[ACC_W-1:0];
    assign o_sat_next = r_sat | w_ovf;

    always_ff @(posedge clk) begin
        if (rst)
            r_sat <= 1'b0;
        else if (i_en)
            r_sat <= i_clear ? 1'b0 : o_sat_next;
    end
`else
    assign o_acc_next = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_acc <= '0;
        else if (i_en)
            r_acc <= i_clear ? '0 : o_acc_next;
    end

endmodule
`default_nettype wire

// File: rtl/unison_iq_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : unison_iq_accumulator
// Brief    : Frames I/Q feedback pulse counts and publishes them on a
//            valid/ready register. Optional macro: UNISON_IQ_SAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module unison_iq_accumulator
    import unison_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  wire logic               clk_master,
    input  wire logic               rst,
    input  wire logic               acc_en,
    input  wire logic [FRAME_W-1:0] frame_len,
    input  wire logic [1:0]         read_out_I,
    input  wire logic [1:0]         read_out_Q,
    output logic                    overrun,
    unison_iq_accumulator_if.master fo
);

    acc_state_e              w_state;
    logic                    w_run;
    logic                    w_last;
    logic                    w_slot_free;
    logic                    w_accept;
    logic signed [ACC_W-1:0] w_next_i;
    logic signed [ACC_W-1:0] w_next_q;

    logic [FRAME_W-1:0]      r_cnt;
    logic [FRAME_W-1:0]      r_cur_len;
    logic signed [ACC_W-1:0] r_frame_i;
    logic signed [ACC_W-1:0] r_frame_q;
    logic                    r_valid;
    logic [7:0]              r_seq;
    logic                    r_overrun;

    // Run/idle is a pure decode of acc_en; frame progress lives in r_cnt.
    assign w_state     = acc_en ? ST_RUN : ST_IDLE;
    assign w_run       = (w_state == ST_RUN);
    assign w_last      = w_run && (r_cnt == r_cur_len);
    assign w_accept    = r_valid && fo.frame_ready;
    assign w_slot_free = !r_valid || fo.frame_ready;

`ifdef UNISON_IQ_SAT_EN
    logic w_sat_i;
    logic w_sat_q;
    logic r_sat;
`endif

    unison_pm_acc #(.ACC_W(ACC_W)) u_acc_i (
        .clk        (clk_master),
        .rst        (rst),
        .i_en       (w_run),
        .i_clear    (w_last),
        .i_pair     (read_out_I),
`ifdef UNISON_IQ_SAT_EN
        .o_sat_next (w_sat_i),
`endif
        .o_acc_next (w_next_i)
    );

    unison_pm_acc #(.ACC_W(ACC_W)) u_acc_q (
        .clk        (clk_master),
        .rst        (rst),
        .i_en       (w_run),
        .i_clear    (w_last),
        .i_pair     (read_out_Q),
`ifdef UNISON_IQ_SAT_EN
        .o_sat_next (w_sat_q),
`endif
        .o_acc_next (w_next_q)
    );

    always_ff @(posedge clk_master) begin
        if (rst) begin
            r_cnt     <= '0;
            r_cur_len <= frame_len;
        end else if (w_run) begin
            if (w_last) begin
                r_cnt     <= '0;
                r_cur_len <= frame_len;
            end else begin
                r_cnt     <= r_cnt + FRAME_W'(1);
            end
        end
    end

    // A closing frame either takes the slot (possibly the same cycle it
    // drains) or is dropped, leaving the held frame untouched.
    always_ff @(posedge clk_master) begin
        if (rst) begin
            r_frame_i <= '0;
            r_frame_q <= '0;
            r_valid   <= 1'b0;
            r_seq     <= '0;
            r_overrun <= 1'b0;
`ifdef UNISON_IQ_SAT_EN
            r_sat     <= 1'b0;
`endif
        end else if (w_last && w_slot_free) begin
            r_frame_i <= w_next_i;
            r_frame_q <= w_next_q;
            r_valid   <= 1'b1;
            r_seq     <= r_seq + 8'd1;
`ifdef UNISON_IQ_SAT_EN
            r_sat     <= w_sat_i | w_sat_q;
`endif
        end else begin
            if (w_accept)
                r_valid <= 1'b0;
            if (w_last)
                r_overrun <= 1'b1;
        end
    end

    assign fo.frame_I     = r_frame_i;
    assign fo.frame_Q     = r_frame_q;
    assign fo.frame_valid = r_valid;
    assign fo.frame_seq   = r_seq;
`ifdef UNISON_IQ_SAT_EN
    assign fo.frame_sat   = r_sat;
`endif
    assign overrun        = r_overrun;

endmodule
`default_nettype wire
